// File: rtl/vend_sequencer.sv
// vend_sequencer: top-level vending machine control FSM.
// It owns the customer credit and the machine vault (machine_money). It
// sequences each purchase as a price check, then a dispense pulse, then a
// change pulse. It also handles the customer refund and owner collect modes.
// Optional build macro: AUTO_REFUND_EN adds an idle timer. While credit is
// held with no accepted coin or select, the timer counts. When it reaches
// TIMEOUT, the credit is refunded automatically.
module vend_sequencer #(
   parameter logic [3:0] PRICE_A = 4'd3,
   parameter logic [3:0] PRICE_B = 4'd5,
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] mode,
   input  logic       coin_valid,
   input  logic [1:0] coin_val,
   input  logic       sel_valid,
   input  logic       sel_id,
   output logic [3:0] credit,
   output logic [3:0] machine_money,
   output logic       dispense,
   output logic       dispense_id,
   output logic       change_valid,
   output logic [3:0] change,
   output logic       collect_valid,
   output logic [3:0] collect_amount,
   output logic       busy,
   output logic       error
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CREDIT,
      ST_VEND,
      ST_CHANGE,
      ST_COLLECT
   } state_t;

   localparam logic [1:0] MODE_COIN    = 2'b00;
   localparam logic [1:0] MODE_BUY     = 2'b01;
   localparam logic [1:0] MODE_COLLECT = 2'b10;
   localparam logic [1:0] MODE_REFUND  = 2'b11;

   state_t     state_q, state_d;
   logic [3:0] credit_q, credit_d;
   logic [3:0] money_q, money_d;
   logic [3:0] price_q, price_d;
   logic       dispense_q, dispense_d;
   logic       dispense_id_q, dispense_id_d;
   logic       change_valid_q, change_valid_d;
   logic [3:0] change_q, change_d;
   logic       collect_valid_q, collect_valid_d;
   logic [3:0] collect_amount_q, collect_amount_d;
   logic       busy_q, busy_d;
   logic       error_q, error_d;

   // Working values for the price and overflow checks.
   logic [3:0] price_sel;
   logic [4:0] coin_sum;
   logic [4:0] vault_sum;
   logic       refund;

`ifdef AUTO_REFUND_EN
   logic [7:0] timer_q, timer_d;
`else
   // Without the auto-refund timer, TIMEOUT has no function. It is folded
   // here only so that the parameter is still referenced.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   assign price_sel = sel_id ? PRICE_B : PRICE_A;
   assign coin_sum  = {1'b0, credit_q} + {3'b000, coin_val};
   assign vault_sum = {1'b0, money_q} + {1'b0, price_sel};

   // Next-state and registered-output computation for every FSM state.
   always_comb begin
      state_d          = state_q;
      credit_d         = credit_q;
      money_d          = money_q;
      price_d          = price_q;
      dispense_d       = 1'b0;
      dispense_id_d    = 1'b0;
      change_valid_d   = 1'b0;
      change_d         = 4'd0;
      collect_valid_d  = 1'b0;
      collect_amount_d = 4'd0;
      error_d          = 1'b0;
      refund           = 1'b0;
`ifdef AUTO_REFUND_EN
      timer_d          = 8'd0;
`endif

      case (state_q)
         ST_IDLE, ST_CREDIT: begin
            case (mode)
               MODE_COIN: begin
                  if (coin_valid && (coin_val != 2'd0)) begin
                     if (coin_sum <= 5'd15) begin
                        credit_d = coin_sum[3:0];
                        state_d  = ST_CREDIT;
                     end else begin
                        error_d = 1'b1;
                     end
                  end
               end
               MODE_BUY: begin
                  if (sel_valid) begin
                     if (credit_q < price_sel) begin
                        error_d = 1'b1;
                     end else if (vault_sum > 5'd15) begin
                        // The vault cannot absorb this sale without wrapping.
                        error_d = 1'b1;
                     end else begin
                        // The dispense pulse and the vault update appear in the VEND cycle.
                        price_d       = price_sel;
                        money_d       = vault_sum[3:0];
                        dispense_d    = 1'b1;
                        dispense_id_d = sel_id;
                        state_d       = ST_VEND;
                     end
                  end
               end
               MODE_COLLECT: begin
                  if (credit_q != 4'd0) begin
                     // A customer transaction is pending, so the owner must wait.
                     error_d = 1'b1;
                  end else begin
                     if (money_q != 4'd0) begin
                        collect_valid_d  = 1'b1;
                        collect_amount_d = money_q;
                        money_d          = 4'd0;
                     end else begin
                        error_d = 1'b1;
                     end
                     state_d = ST_COLLECT;
                  end
               end
               default: begin
                  // Refund mode has no effect in IDLE because there is no credit to return.
                  if (state_q == ST_CREDIT) begin
                     refund = 1'b1;
                  end
               end
            endcase

`ifdef AUTO_REFUND_EN
            // The timer counts only while the customer does nothing useful in CREDIT.
            if ((state_q == ST_CREDIT) && (state_d == ST_CREDIT) &&
                (credit_d == credit_q) && !refund) begin
               if (timer_q + 8'd1 == TIMEOUT) begin
                  refund = 1'b1;
               end else begin
                  timer_d = timer_q + 8'd1;
               end
            end
`endif

            if (refund) begin
               change_valid_d = 1'b1;
               change_d       = credit_q;
               credit_d       = 4'd0;
               state_d        = ST_IDLE;
            end
         end

         ST_VEND: begin
            // The balance goes back as change. A zero balance produces no pulse.
            change_d       = credit_q - price_q;
            change_valid_d = (credit_q != price_q);
            credit_d       = 4'd0;
            state_d        = ST_CHANGE;
         end

         ST_CHANGE: begin
            state_d = ST_IDLE;
         end

         ST_COLLECT: begin
            // Only one payout is made per entry into collect mode.
            if (mode != MODE_COLLECT) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
   end

   // State and output registers, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         credit_q         <= 4'd0;
         money_q          <= 4'd0;
         price_q          <= 4'd0;
         dispense_q       <= 1'b0;
         dispense_id_q    <= 1'b0;
         change_valid_q   <= 1'b0;
         change_q         <= 4'd0;
         collect_valid_q  <= 1'b0;
         collect_amount_q <= 4'd0;
         busy_q           <= 1'b0;
         error_q          <= 1'b0;
      end else begin
         state_q          <= state_d;
         credit_q         <= credit_d;
         money_q          <= money_d;
         price_q          <= price_d;
         dispense_q       <= dispense_d;
         dispense_id_q    <= dispense_id_d;
         change_valid_q   <= change_valid_d;
         change_q         <= change_d;
         collect_valid_q  <= collect_valid_d;
         collect_amount_q <= collect_amount_d;
         busy_q           <= busy_d;
         error_q          <= error_d;
      end
   end

`ifdef AUTO_REFUND_EN
   // Idle timer register used for the automatic refund.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_q <= 8'd0;
      end else begin
         timer_q <= timer_d;
      end
   end
`endif

   assign credit         = credit_q;
   assign machine_money  = money_q;
   assign dispense       = dispense_q;
   assign dispense_id    = dispense_id_q;
   assign change_valid   = change_valid_q;
   assign change         = change_q;
   assign collect_valid  = collect_valid_q;
   assign collect_amount = collect_amount_q;
   assign busy           = busy_q;
   assign error          = error_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Testbench for vend_sequencer in its default build (AUTO_REFUND_EN undefined).
// Directed table vectors, hand sequences, then random traffic vs a model.
module tb_vend_sequencer;

   logic       clk;
   logic       rst_n;
   logic [1:0] mode;
   logic       coin_valid;
   logic [1:0] coin_val;
   logic       sel_valid;
   logic       sel_id;
   logic [3:0] credit;
   logic [3:0] machine_money;
   logic       dispense;
   logic       dispense_id;
   logic       change_valid;
   logic [3:0] change;
   logic       collect_valid;
   logic [3:0] collect_amount;
   logic       busy;
   logic       error;

   int checks   = 0;
   int failures = 0;

   vend_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mode           (mode),
      .coin_valid     (coin_valid),
      .coin_val       (coin_val),
      .sel_valid      (sel_valid),
      .sel_id         (sel_id),
      .credit         (credit),
      .machine_money  (machine_money),
      .dispense       (dispense),
      .dispense_id    (dispense_id),
      .change_valid   (change_valid),
      .change         (change),
      .collect_valid  (collect_valid),
      .collect_amount (collect_amount),
      .busy           (busy),
      .error          (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply inputs, clock once, and settle 1 ns after the edge.
   task automatic tick(input logic [1:0] m, input logic cv, input logic [1:0] cval,
                       input logic sv, input logic sid);
      mode       = m;
      coin_valid = cv;
      coin_val   = cval;
      sel_valid  = sv;
      sel_id     = sid;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   // ---------------- behavioural reference model ----------------
   int   m_credit, m_money, m_txn, m_price;
   bit   m_collect;
   logic e_disp, e_disp_id, e_cv, e_colv, e_busy, e_err;
   int   e_change, e_cola;

   function automatic int price_of(input logic id);
      return id ? 5 : 3;
   endfunction

   // Predicts the outputs after the next edge from the current inputs.
   task automatic model_step();
      int p;
      e_disp = 0; e_disp_id = 0; e_cv = 0; e_change = 0;
      e_colv = 0; e_cola = 0; e_err = 0;
      if (!rst_n) begin
         m_credit = 0; m_money = 0; m_txn = 0; m_price = 0; m_collect = 0;
      end else if (m_txn == 2) begin
         e_change = m_credit - m_price;
         e_cv     = (e_change != 0);
         m_credit = 0;
         m_txn    = 1;
      end else if (m_txn == 1) begin
         m_txn = 0;
      end else if (m_collect) begin
         if (mode != 2'd2) m_collect = 0;
      end else begin
         case (mode)
            2'd0: if (coin_valid && coin_val != 0) begin
               if (m_credit + int'(coin_val) <= 15) m_credit += int'(coin_val);
               else e_err = 1;
            end
            2'd1: if (sel_valid) begin
               p = price_of(sel_id);
               if (m_credit < p) e_err = 1;
               else if (m_money + p > 15) e_err = 1;
               else begin
                  m_money  += p;
                  m_price   = p;
                  m_txn     = 2;
                  e_disp    = 1;
                  e_disp_id = sel_id;
               end
            end
            2'd2: begin
               if (m_credit != 0) e_err = 1;
               else begin
                  if (m_money != 0) begin
                     e_colv  = 1;
                     e_cola  = m_money;
                     m_money = 0;
                  end else e_err = 1;
                  m_collect = 1;
               end
            end
            default: if (m_credit != 0) begin
               e_cv     = 1;
               e_change = m_credit;
               m_credit = 0;
            end
         endcase
      end
      e_busy = (m_txn != 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [1:0] mode;
      logic       cv;
      logic [1:0] cval;
      logic       sv;
      logic       sid;
      logic [3:0] x_credit;
      logic [3:0] x_money;
      logic       x_disp;
      logic       x_chv;
      logic [3:0] x_chg;
      logic       x_colv;
      logic [3:0] x_cola;
      logic       x_err;
   } vec_t;

   localparam int NVEC = 31;
   vec_t vecs[NVEC];

   int nbuy;
   int npulse;
   logic [3:0] last_amt;

   initial begin
      //          mode  cv  cval  sv  sid  cred  money disp chv chg  colv cola err
      vecs[0]  = '{2'd0,1'b1,2'd2,1'b0,1'b0,4'd2, 4'd0,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[1]  = '{2'd0,1'b1,2'd2,1'b0,1'b0,4'd4, 4'd0,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[2]  = '{2'd1,1'b0,2'd0,1'b1,1'b0,4'd4, 4'd3,1'b1,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[3]  = '{2'd1,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd3,1'b0,1'b1,4'd1, 1'b0,4'd0,1'b0};
      vecs[4]  = '{2'd0,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[5]  = '{2'd0,1'b1,2'd3,1'b0,1'b0,4'd3, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[6]  = '{2'd0,1'b1,2'd3,1'b0,1'b0,4'd6, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[7]  = '{2'd0,1'b1,2'd3,1'b0,1'b0,4'd9, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[8]  = '{2'd0,1'b1,2'd3,1'b0,1'b0,4'd12,4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[9]  = '{2'd0,1'b1,2'd2,1'b0,1'b0,4'd14,4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[10] = '{2'd0,1'b1,2'd3,1'b0,1'b0,4'd14,4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b1};
      vecs[11] = '{2'd0,1'b1,2'd1,1'b0,1'b0,4'd15,4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[12] = '{2'd3,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd3,1'b0,1'b1,4'd15,1'b0,4'd0,1'b0};
      vecs[13] = '{2'd0,1'b1,2'd3,1'b0,1'b0,4'd3, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[14] = '{2'd0,1'b1,2'd1,1'b0,1'b0,4'd4, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[15] = '{2'd1,1'b0,2'd0,1'b1,1'b1,4'd4, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b1};
      vecs[16] = '{2'd3,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd3,1'b0,1'b1,4'd4, 1'b0,4'd0,1'b0};
      vecs[17] = '{2'd3,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[18] = '{2'd2,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd0,1'b0,1'b0,4'd0, 1'b1,4'd3,1'b0};
      vecs[19] = '{2'd2,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd0,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[20] = '{2'd0,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd0,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[21] = '{2'd2,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd0,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b1};
      vecs[22] = '{2'd0,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd0,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[23] = '{2'd1,1'b1,2'd3,1'b0,1'b0,4'd0, 4'd0,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[24] = '{2'd0,1'b1,2'd0,1'b0,1'b0,4'd0, 4'd0,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[25] = '{2'd0,1'b0,2'd0,1'b1,1'b0,4'd0, 4'd0,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[26] = '{2'd0,1'b1,2'd3,1'b0,1'b0,4'd3, 4'd0,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[27] = '{2'd1,1'b0,2'd0,1'b1,1'b0,4'd3, 4'd3,1'b1,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[28] = '{2'd0,1'b1,2'd3,1'b0,1'b0,4'd0, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[29] = '{2'd0,1'b1,2'd2,1'b0,1'b0,4'd0, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};
      vecs[30] = '{2'd0,1'b0,2'd0,1'b0,1'b0,4'd0, 4'd3,1'b0,1'b0,4'd0, 1'b0,4'd0,1'b0};

      rst_n = 1'b0; mode = 2'd0; coin_valid = 1'b0; coin_val = 2'd0;
      sel_valid = 1'b0; sel_id = 1'b0;
      do_reset();
      chk("reset_credit", 8'(credit), 8'd0);
      chk("reset_money", 8'(machine_money), 8'd0);
      chk("reset_pulses", 8'({dispense, change_valid, collect_valid, error}), 8'd0);
      chk("reset_busy", 8'(busy), 8'd0);

      for (int i = 0; i < NVEC; i++) begin
         tick(vecs[i].mode, vecs[i].cv, vecs[i].cval, vecs[i].sv, vecs[i].sid);
         $display("vec %0d mode=%0d coin=%0d/%0d sel=%0d/%0d -> credit=%0d money=%0d err=%0d",
                  i, vecs[i].mode, vecs[i].cv, vecs[i].cval, vecs[i].sv, vecs[i].sid,
                  credit, machine_money, error);
         chk($sformatf("vec%0d_credit", i), 8'(credit), 8'(vecs[i].x_credit));
         chk($sformatf("vec%0d_money", i), 8'(machine_money), 8'(vecs[i].x_money));
         chk($sformatf("vec%0d_dispense", i), 8'(dispense), 8'(vecs[i].x_disp));
         if (vecs[i].x_disp) chk($sformatf("vec%0d_disp_id", i), 8'(dispense_id), 8'(vecs[i].sid));
         chk($sformatf("vec%0d_change_valid", i), 8'(change_valid), 8'(vecs[i].x_chv));
         if (vecs[i].x_chv) chk($sformatf("vec%0d_change", i), 8'(change), 8'(vecs[i].x_chg));
         chk($sformatf("vec%0d_collect_valid", i), 8'(collect_valid), 8'(vecs[i].x_colv));
         if (vecs[i].x_colv) chk($sformatf("vec%0d_collect_amt", i), 8'(collect_amount), 8'(vecs[i].x_cola));
         chk($sformatf("vec%0d_error", i), 8'(error), 8'(vecs[i].x_err));
      end

      // Vault-full rejection, then collect, then a successful repeat purchase.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         tick(2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
         tick(2'd1, 1'b0, 2'd0, 1'b1, 1'b0);
         tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
         tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      end
      $display("seq vault: four product A sales, money=%0d", machine_money);
      chk("vault_12", 8'(machine_money), 8'd12);
      tick(2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
      tick(2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
      tick(2'd1, 1'b0, 2'd0, 1'b1, 1'b1);
      $display("seq vault: select B with full vault, err=%0d disp=%0d", error, dispense);
      chk("vault_full_err", 8'(error), 8'd1);
      chk("vault_full_nodisp", 8'(dispense), 8'd0);
      chk("vault_full_credit", 8'(credit), 8'd5);
      tick(2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("vault_refund_chv", 8'(change_valid), 8'd1);
      chk("vault_refund_amt", 8'(change), 8'd5);
      tick(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
      $display("seq vault: collect amount=%0d", collect_amount);
      chk("vault_collect_v", 8'(collect_valid), 8'd1);
      chk("vault_collect_amt", 8'(collect_amount), 8'd12);
      chk("vault_emptied", 8'(machine_money), 8'd0);
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      tick(2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
      tick(2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
      tick(2'd1, 1'b0, 2'd0, 1'b1, 1'b1);
      $display("seq vault: repeat select B, disp=%0d money=%0d", dispense, machine_money);
      chk("rebuy_disp", 8'(dispense), 8'd1);
      chk("rebuy_disp_id", 8'(dispense_id), 8'd1);
      chk("rebuy_money", 8'(machine_money), 8'd5);
      chk("rebuy_busy_vend", 8'(busy), 8'd1);
      tick(2'd3, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("rebuy_no_change", 8'(change_valid), 8'd0);
      chk("rebuy_busy_change", 8'(busy), 8'd1);
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("rebuy_idle_busy", 8'(busy), 8'd0);

      // A held collect mode pays out once; re-entry with an empty vault is rejected.
      do_reset();
      tick(2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
      tick(2'd1, 1'b0, 2'd0, 1'b1, 1'b0);
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      tick(2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
      tick(2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
      tick(2'd1, 1'b0, 2'd0, 1'b1, 1'b1);
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("vault_8", 8'(machine_money), 8'd8);
      npulse = 0; last_amt = 4'd0;
      for (int k = 0; k < 5; k++) begin
         tick(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
         if (collect_valid) begin
            npulse++;
            last_amt = collect_amount;
         end
      end
      $display("seq collect: held 5 cycles, pulses=%0d amount=%0d", npulse, last_amt);
      chk("collect_once", 8'(npulse), 8'd1);
      chk("collect_amt8", 8'(last_amt), 8'd8);
      chk("collect_money0", 8'(machine_money), 8'd0);
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      tick(2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("collect_empty_err", 8'(error), 8'd1);
      chk("collect_empty_nopay", 8'(collect_valid), 8'd0);
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);

      // Reset asserted during the VEND cycle abandons the transaction.
      do_reset();
      tick(2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
      tick(2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
      tick(2'd1, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("rst_vend_disp", 8'(dispense), 8'd1);
      rst_n = 1'b0;
      tick(2'd1, 1'b0, 2'd0, 1'b0, 1'b0);
      $display("seq reset-in-vend: chv=%0d credit=%0d money=%0d", change_valid, credit, machine_money);
      chk("rst_vend_nochange", 8'(change_valid), 8'd0);
      chk("rst_vend_credit", 8'(credit), 8'd0);
      chk("rst_vend_money", 8'(machine_money), 8'd0);
      chk("rst_vend_busy", 8'(busy), 8'd0);
      rst_n = 1'b1;
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk("rst_vend_after_chv", 8'(change_valid), 8'd0);

      // Random traffic against the reference model.
      rst_n = 1'b0;
      model_step();
      tick(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      nbuy = 0;
      for (int c = 0; c < 4000; c++) begin
         int r;
         r = int'($urandom_range(0, 9));
         mode       = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
         coin_valid = 1'($urandom_range(0, 1));
         coin_val   = 2'($urandom_range(0, 3));
         sel_valid  = 1'($urandom_range(0, 1));
         sel_id     = 1'($urandom_range(0, 1));
         rst_n      = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         model_step();
         @(posedge clk);
         #1;
         chk("rnd_credit", 8'(credit), 8'(m_credit));
         chk("rnd_money", 8'(machine_money), 8'(m_money));
         chk("rnd_dispense", 8'(dispense), 8'(e_disp));
         if (e_disp) begin
            nbuy++;
            chk("rnd_disp_id", 8'(dispense_id), 8'(e_disp_id));
            $display("rnd cycle %0d: purchase id=%0d money=%0d", c, dispense_id, machine_money);
         end
         chk("rnd_change_valid", 8'(change_valid), 8'(e_cv));
         if (e_cv) chk("rnd_change", 8'(change), 8'(e_change));
         chk("rnd_collect_valid", 8'(collect_valid), 8'(e_colv));
         if (e_colv) chk("rnd_collect_amt", 8'(collect_amount), 8'(e_cola));
         chk("rnd_busy", 8'(busy), 8'(e_busy));
         chk("rnd_error", 8'(error), 8'(e_err));
      end
      rst_n = 1'b1;
      $display("random phase: %0d purchases", nbuy);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
